// File: rtl/bp_pkg.sv
// Shared types and default sizes for the gshare PHT controller (bp_ctrl).
package bp_pkg;

    localparam int BP_IDX_W     = 5;
    localparam int BP_HIST_W    = 5;
    // Slot and queue index fields are sized for the widest supported PHT.
    localparam int BP_IDX_MAX_W = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [BP_IDX_MAX_W-1:0] idx;
        logic                    pred;
    } bp_slot_t;

    typedef struct packed {
        logic [BP_IDX_MAX_W-1:0] idx;
        logic                    taken;
    } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of pending PHT counter updates; a push into a full queue
// is still accepted when a pop happens in the same cycle. No write-to-read bypass.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  bp_upd_t                din,
    input  logic                   pop,
    output bp_upd_t                dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    bp_upd_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bp_ctrl.sv
// gshare PHT controller: GHR, lookup index, IF/ID/EX shadow slots, mispredict
// detection and PHT write scheduling. Optional counters under BP_CTRL_STATS_EN.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W    = BP_IDX_W,
    parameter int HIST_W   = BP_HIST_W,
    parameter int Q_DEPTH  = 4,
    parameter     INIT_CNT = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       if_pc,
    output logic [IDX_W-1:0]  lookup_idx,
    input  logic              lookup_taken,
    output logic              pred_taken,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    output logic              upd_init,
    output logic [IDX_W-1:0]  upd_idx,
    output logic              upd_taken,
    input  logic              upd_ready,
    output logic              init_done,
    output logic [HIST_W-1:0] ghr,
    output bp_state_e         fsm_state,
    output logic [2:0]        slot_valid
`ifdef BP_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred,
    output logic [31:0]       stat_drops
`endif
);

    if (HIST_W < 2 || HIST_W > IDX_W || IDX_W > BP_IDX_MAX_W || Q_DEPTH < 2 ||
        (Q_DEPTH & (Q_DEPTH - 1)) != 0 || $bits(INIT_CNT) != 2) begin : g_bad_params
        $error("bp_ctrl: illegal parameterisation");
    end

    bp_state_e                state, state_next;
    logic [IDX_W-1:0]         init_cnt;
    bp_slot_t                 if_s, id_s, ex_s;
    bp_upd_t                  q_head;
    logic [$clog2(Q_DEPTH):0] q_count;
    logic                     q_full, q_empty, pop, accepted;
    logic                     unused_bits;

    assign lookup_idx  = if_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign accepted    = ex_is_branch & ex_s.valid & ~stall;
    assign mispredict  = accepted & (ex_taken != ex_s.pred);
    assign redirect_pc = ex_taken ? ex_target : ex_s.pc + 32'd4;
    assign init_done   = (state == ST_RUN);
    assign fsm_state   = state;
    assign slot_valid  = {ex_s.valid, id_s.valid, if_s.valid};
    assign unused_bits = ^{ex_s.idx, q_head.idx, q_count, q_full};

    // Write port: a write transfers on the cycle upd_valid & upd_ready are both
    // high; upd_valid never depends on upd_ready and, once raised, the request
    // (upd_init/upd_idx/upd_taken) holds until that transfer.
    always_comb begin
        state_next = state;
        upd_valid  = 1'b0;
        upd_init   = 1'b0;
        upd_idx    = '0;
        upd_taken  = 1'b0;
        pred_taken = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_INIT: begin
                upd_valid = 1'b1;
                upd_init  = 1'b1;
                upd_idx   = init_cnt;
                if (upd_ready && init_cnt == '1) state_next = ST_RUN;
            end
            ST_RUN: begin
                pred_taken = lookup_taken;
                upd_valid  = ~q_empty;
                upd_idx    = IDX_W'(q_head.idx);
                upd_taken  = q_head.taken;
                pop        = ~q_empty & upd_ready;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ghr      <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT && upd_ready) init_cnt <= init_cnt + 1'b1;
            if (accepted) ghr <= {ghr[HIST_W-2:0], ex_taken};
        end
    end

    // A redirect kills the two younger slots; EX inherits the dead ID slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_s <= '0;
            id_s <= '0;
            ex_s <= '0;
        end else if (!stall) begin
            if (mispredict) begin
                if_s <= '0;
                id_s <= '0;
                ex_s <= '{valid: 1'b0, pc: id_s.pc, idx: id_s.idx, pred: id_s.pred};
            end else begin
                if_s <= '{valid: 1'b1, pc: if_pc,
                          idx: BP_IDX_MAX_W'(lookup_idx), pred: pred_taken};
                id_s <= if_s;
                ex_s <= id_s;
            end
        end
    end

    bp_upd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accepted),
        .din   ('{idx: ex_s.idx, taken: ex_taken}),
        .pop   (pop),
        .dout  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

`ifdef BP_CTRL_STATS_EN
    logic q_drop;
    assign q_drop = accepted & q_full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
            stat_drops    <= '0;
        end else begin
            if (accepted   && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispred  != '1) stat_mispred  <= stat_mispred + 32'd1;
            if (q_drop     && stat_drops    != '1) stat_drops    <= stat_drops + 32'd1;
        end
    end
`endif

endmodule
